// File: rtl/trig_lut_scheduler.sv
// Round-robin scheduler sharing one piecewise-linear trig evaluator (LUT m/b + multiply-add) among N_REQ requesters.
// Latency: accept T, lut_en T+1, rsp_valid T+2+LUT_LAT (T+2 on a cache hit); one evaluation in flight at a time.
// Backpressure: req_ready only in IDLE; the result holds in RESP until rsp_ready. Optional cache: TRIG_LUT_SCHED_BYPASS_EN.
module trig_lut_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LUT_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_angle,
    input  logic [N_REQ-1:0]      req_op,
    output logic                  lut_en,
    output logic [11:0]           lut_addr,
    input  logic [31:0]           lut_grad,
    input  logic [63:0]           lut_icpt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, CALC, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, winner;
    logic              found, accept, hit;
    logic [31:0]       win_angle, adj_angle;
    logic [19:0]       frac_q;
    logic [2:0]        cnt;
    logic [31:0]       grad_use;
    logic [63:0]       icpt_use, prod;

    // First valid requester at or after the pointer, modulo N_REQ.
    always_comb begin : arb
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign req_ready = accept ? (N_REQ'(1) << winner) : '0;
    assign win_angle = req_angle[32*winner +: 32];
    // sin(x) = cos(x - pi/2): quarter turn is 2^30.
    assign adj_angle = req_op[winner] ? (win_angle - 32'h4000_0000) : win_angle;

`ifdef TRIG_LUT_SCHED_BYPASS_EN
    logic        cache_vld, use_cache;
    logic [11:0] cache_idx;
    logic [31:0] cache_grad;
    logic [63:0] cache_icpt;

    assign hit      = cache_vld && (cache_idx == adj_angle[31:20]);
    assign grad_use = use_cache ? cache_grad : lut_grad;
    assign icpt_use = use_cache ? cache_icpt : lut_icpt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld  <= 1'b0;
            use_cache  <= 1'b0;
            cache_idx  <= '0;
            cache_grad <= '0;
            cache_icpt <= '0;
        end else begin
            if (accept)
                use_cache <= hit;
            if (state == CALC && !use_cache) begin
                cache_vld  <= 1'b1;
                cache_idx  <= lut_addr;
                cache_grad <= lut_grad;
                cache_icpt <= lut_icpt;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign grad_use = lut_grad;
    assign icpt_use = lut_icpt;
`endif

    // Low 64 bits of the sign-extended product equal the wrapped signed result.
    assign prod = {{32{grad_use[31]}}, grad_use} * {44'd0, frac_q};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = hit ? CALC : LOOKUP;
            LOOKUP:  state_nxt = (LUT_LAT == 1) ? CALC : WAIT;
            WAIT:    if (cnt <= 3'd1) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            frac_q   <= '0;
            lut_addr <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr      <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                lut_addr <= adj_angle[31:20];
                frac_q   <= adj_angle[19:0];
                rsp_id   <= winner;
            end
            if (state == LOOKUP)
                cnt <= 3'(LUT_LAT - 1);
            else if (state == WAIT)
                cnt <= cnt - 3'd1;
            if (state == CALC)
                rsp_data <= icpt_use + prod;
        end
    end

    assign lut_en    = (state == LOOKUP);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Directed bench for trig_lut_scheduler: LUT model with LUT_LAT pipeline, scoreboard queue of expected responses.
module tb_trig_lut_scheduler;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid, req_ready, req_op;
    logic [32*N-1:0] req_angle;
    logic         lut_en;
    logic [11:0]  lut_addr;
    logic [31:0]  lut_grad;
    logic [63:0]  lut_icpt;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        int          t_acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    bit          c_vld = 1'b0;
    logic [11:0] c_idx = '0;

    trig_lut_scheduler #(.N_REQ(N), .LUT_LAT(LAT), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle), .req_op(req_op),
        .lut_en(lut_en), .lut_addr(lut_addr), .lut_grad(lut_grad), .lut_icpt(lut_icpt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] gf(input logic [11:0] i);
        if (i == 12'd4095) return 32'hFFFF_FFFB;
        return 32'(i) * 32'd7919 - 32'd9000000;
    endfunction

    function automatic logic [63:0] bf(input logic [11:0] i);
        if (i == 12'd4095) return 64'd1000;
        return {i, 52'h0} + 64'(i) * 64'd12345 + 64'd77;
    endfunction

    // ROM model: data is only meaningful exactly LAT cycles after the lut_en cycle.
    logic        p_vld [LAT];
    logic [11:0] p_addr[LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                p_vld[k]  <= 1'b0;
                p_addr[k] <= '0;
            end
        end else begin
            p_vld[0]  <= lut_en;
            p_addr[0] <= lut_addr;
            for (int k = 1; k < LAT; k++) begin
                p_vld[k]  <= p_vld[k-1];
                p_addr[k] <= p_addr[k-1];
            end
        end
    end
    assign lut_grad = p_vld[LAT-1] ? gf(p_addr[LAT-1]) : 32'hBAD0_BAD0;
    assign lut_icpt = p_vld[LAT-1] ? bf(p_addr[LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setreq(input int id, input logic [31:0] ang, input logic op);
        req_angle[32*id +: 32] = ang;
        req_op[id]             = op;
        req_valid[id]          = 1'b1;
    endtask

    // Wait for a grant to requester id, queue its expected result, check the LUT strobe.
    task automatic wait_grant(input int id, input bit drop);
        bit          got;
        bit          hit;
        logic [31:0] a;
        logic [11:0] idx;
        logic [19:0] fr;
        logic [63:0] d;
        int          c;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            #1;
            if (|req_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("grant_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("req_ready", 64'(req_ready), 64'(1) << id);
        c   = cyc;
        a   = req_angle[32*id +: 32];
        if (req_op[id]) a = a - 32'h4000_0000;
        idx = a[31:20];
        fr  = a[19:0];
`ifdef TRIG_LUT_SCHED_BYPASS_EN
        hit   = c_vld && (c_idx == idx);
        c_vld = 1'b1;
        c_idx = idx;
`else
        hit = 1'b0;
`endif
        d = bf(idx) + 64'(longint'($signed(gf(idx))) * longint'(fr));
        sb.push_back('{2'(id), d, c, hit ? 2 : 2 + LAT});
        @(negedge clk);
        if (drop) req_valid[id] = 1'b0;
        chk("busy", 64'(busy), 64'd1);
        chk("lut_en", 64'(lut_en), 64'(!hit));
        if (!hit) chk("lut_addr", 64'(lut_addr), 64'(idx));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("lut_en_off", 64'(lut_en), 64'd0);
        if (!hit) chk("lut_addr_hold", 64'(lut_addr), 64'(idx));
    endtask

    task automatic collect(input int stall);
        bit          got;
        exp_t        e;
        logic [63:0] d;
        logic [1:0]  i;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("rsp_seen", 64'(got), 64'd1);
        if (!got || sb.size() == 0) return;
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.t_acc), 64'(e.lat));
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", rsp_data, e.data);
        d = rsp_data;
        i = rsp_id;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_data", rsp_data, d);
            chk("stall_id", 64'(rsp_id), 64'(i));
            chk("stall_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_angle = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lut_en", 64'(lut_en), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        setreq(0, 32'h0000_0000, 1'b0); wait_grant(0, 1); collect(0);
        setreq(1, 32'h0000_0000, 1'b1); wait_grant(1, 1); collect(0);
        setreq(3, 32'hFFFF_FFFC, 1'b0); wait_grant(3, 1); collect(0);
        setreq(2, 32'hFFFF_FFFF, 1'b0); wait_grant(2, 1); collect(0);

        // Pointer now 3: 0101 held grants 0 then 2, re-presented wraps to 0.
        setreq(0, 32'h1234_5678, 1'b0);
        setreq(2, 32'h9ABC_DEF0, 1'b1);
        wait_grant(0, 0); collect(0);
        wait_grant(2, 1); collect(0);
        req_valid[2] = 1'b1;
        wait_grant(0, 1);
        req_valid = '0;
        setreq(1, 32'h5555_5555, 1'b1);
        collect(5);
        wait_grant(1, 1); collect(0);

        setreq(0, 32'h0010_0000, 1'b0); wait_grant(0, 1); collect(0);
        setreq(0, 32'h0018_0000, 1'b0); wait_grant(0, 1); collect(0);

        // Reset while the evaluation sits in WAIT.
        setreq(2, 32'h8000_0000, 1'b0); wait_grant(2, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lut_en", 64'(lut_en), 64'd0);
        chk("mid_rst_lut_addr", 64'(lut_addr), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("mid_rst_rsp_data", rsp_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        sb.delete();
        c_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'd0);

        setreq(0, 32'h2000_0000, 1'b1);
        setreq(3, 32'h7000_0000, 1'b0);
        wait_grant(0, 1); collect(0);
        wait_grant(3, 1); collect(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
